load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and LSU state type.
// Also holds the legality and alignment helpers used at accept time.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_e;

  function automatic logic lsu_legal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B)  || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic lsu_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    if (f3[1:0] == 2'b01) return !off[0];
    if (f3[1:0] == 2'b10) return off == 2'b00;
    return 1'b1;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; size comes from funct3, lane from the address offset.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  mask_base;
  logic [31:0] rsh;

  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign wmask_o = mask_base << off_i;
  assign rsh     = rdata_i >> {off_i, 3'b000};

  always_comb begin
    mask_base = 4'b0000;
    unique case (funct3_i[1:0])
      2'b00:   mask_base = 4'b0001;
      2'b01:   mask_base = 4'b0011;
      2'b10:   mask_base = 4'b1111;
      default: mask_base = 4'b0000;
    endcase
  end

  always_comb begin
    rdata_o = rsh;
    unique case (1'b1)
      (funct3_i == F3_B):  rdata_o = {{24{rsh[7]}}, rsh[7:0]};
      (funct3_i == F3_H):  rdata_o = {{16{rsh[15]}}, rsh[15:0]};
      (funct3_i == F3_BU): rdata_o = {24'h0, rsh[7:0]};
      (funct3_i == F3_HU): rdata_o = {16'h0, rsh[15:0]};
      default:             rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one transaction at a time, valid/ready on both sides.
// Memory read data arrives MEM_LATENCY cycles after the read strobe.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);

  lsu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle;
  logic        ok;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign idle = (state_q == ST_IDLE);
  assign ok   = lsu_legal(req_we, req_funct3) &&
                lsu_aligned(req_funct3, req_addr[1:0]);

  // While idle the aligner steers the incoming request, otherwise the latched one.
  assign al_f3  = idle ? req_funct3 : f3_q;
  assign al_off = idle ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .funct3_i (al_f3),
    .off_i    (al_off),
    .wdata_i  (req_wdata),
    .rdata_i  (mem_rdata),
    .wmask_o  (al_wmask),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = al_wdata;
          rdata_d = '0;
          err_d   = !ok;
          if (!ok)        state_d = ST_DONE;
          else if (req_we) state_d = ST_WRITE;
          else            state_d = ST_READ;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_READ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == LAST) begin
          rdata_d = al_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = idle;
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = (state_q == ST_WRITE) ? al_wmask : 4'b0000;
  assign mem_rstrb  = (state_q == ST_READ);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit with a word-array memory.
// Expected responses come from a byte-level model of RV32I load/store rules.
module tb_load_store_unit;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'hDEADBEEF;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int          wcnt = 0;
  int          rcnt = 0;
  int          pend = 0;
  logic [31:0] rd_addr = 32'h0;
  logic [3:0]  last_wmask = 4'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_waddr = 32'h0;

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: sample DUT strobes mid-cycle, return data LAT cycles later.
  always @(negedge clk) begin
    if (mem_wmask != 4'b0000) begin
      wcnt++;
      last_wmask = mem_wmask;
      last_wdata = mem_wdata;
      last_waddr = mem_addr;
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b])
          mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
    if (mem_rstrb) begin
      rcnt++;
      rd_addr   = mem_addr;
      mem_rdata = 32'hDEADBEEF;
      pend      = LAT;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) mem_rdata = mem[rd_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd,
                                output int lat);
    int size, off, idx;
    logic legal;
    logic [31:0] v;
    size  = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    off   = int'(a % 4);
    idx   = int'(a[9:2]);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = 1'b0;
    rd    = 32'h0;
    if (!legal || (a % size) != 0) begin
      err = 1'b1;
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++)
        ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
      lat = 2;
    end else begin
      v = ref_mem[idx] >> (8 * off);
      if (size == 1) begin
        v = v % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      rd  = v;
      lat = 2 + LAT;
    end
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input string tag);
    logic        e;
    logic [31:0] r;
    int lat, cyc, w0, r0;
    model(we, f3, a, wd, e, r, lat);
    w0 = wcnt;
    r0 = rcnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " rdata"}, resp_rdata, r);
    check({tag, " error"}, 32'(resp_error), 32'(e));
    @(negedge clk);
    check({tag, " wmask cycles"}, 32'(wcnt - w0), 32'(we && !e));
    check({tag, " rstrb cycles"}, 32'(rcnt - r0), 32'(!we && !e));
    if (we && !e)
      check({tag, " mem word"}, mem[a[9:2]], ref_mem[a[9:2]]);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({tag, " released"}, 32'({resp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    logic [31:0] held;
    int w0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h40]     = 32'h8899AABB;
    ref_mem[8'h40] = 32'h8899AABB;

    #12;
    check("reset outs", {resp_valid, resp_error, mem_rstrb, mem_wmask},
          32'h0);
    check("reset rdata", resp_rdata, 32'h0);
    check("reset addr", mem_addr, 32'h0);
    check("reset wdata", mem_wdata, 32'h0);
    check("reset ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    run_txn(1'b0, 3'b000, 32'h103, 32'h0, "LB 103");
    run_txn(1'b0, 3'b100, 32'h102, 32'h0, "LBU 102");
    run_txn(1'b0, 3'b001, 32'h102, 32'h0, "LH 102");
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, "LW 100");
    run_txn(1'b1, 3'b000, 32'h101, 32'h12345678, "SB 101");
    check("SB wmask", 32'(last_wmask), 32'h2);
    check("SB lane", last_wdata & 32'h0000FF00, 32'h00007800);
    check("SB addr", last_waddr, 32'h100);
    run_txn(1'b1, 3'b001, 32'h103, 32'hCAFEF00D, "SH 103");
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, "LD f3=011");
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, "LW after SB");

    // Hold the response while a competing store is offered.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h104;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10 && !resp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    held = resp_rdata;
    check("hold rdata", held, ref_mem[8'h41]);
    w0 = wcnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold %0d", i),
            {resp_valid, req_ready, resp_error, resp_rdata[28:0]},
            {1'b1, 1'b0, 1'b0, held[28:0]});
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("hold no write", 32'(wcnt - w0), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, "LW after hold");

    // Abort a load while it waits for memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h108;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("abort outs", {resp_valid, resp_error, mem_rstrb, mem_wmask},
          32'h0);
    check("abort rdata", resp_rdata, 32'h0);
    check("abort addr", mem_addr, 32'h0);
    check("abort ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort quiet %0d", i), 32'(resp_valid), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(1));
      f3 = 3'($urandom_range(7));
      a  = 32'h100 + 32'($urandom_range(63));
      run_txn(we, f3, a, $urandom, $sformatf("rnd%0d", i));
    end

    for (int i = 8'h40; i < 8'h50; i++)
      check($sformatf("mem[%0h]", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
